// File: rtl/gcd_lcm_pkg.sv
// Shared types and constants for the GCD/LCM job dispatcher.
//   state_e   : dispatcher FSM states
//   MODE_*    : job mode encoding (0 = GCD, 1 = LCM)
//   W_DEFAULT : default operand/result width
package gcd_lcm_pkg;

    localparam int unsigned W_DEFAULT = 8;

    localparam logic MODE_GCD = 1'b0;
    localparam logic MODE_LCM = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRun,
        StHold
    } state_e;

endpackage

// File: rtl/gcd_lcm_dispatcher_if.sv
// Job/result stream and core-side signals of the GCD/LCM dispatcher.
//   in_*   : job stream (valid/ready), operands and mode
//   out_*  : result stream (valid/ready), result, mode, error flag
//   core_* : operand/control outputs to the core and its ready/result
// Modports: slave = dispatcher side, master = environment side.
interface gcd_lcm_dispatcher_if
    import gcd_lcm_pkg::*;
#(
    parameter int unsigned W = W_DEFAULT
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_mode;

    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic         out_mode;
    logic         out_err;

    logic [W-1:0] core_a;
    logic [W-1:0] core_b;
    logic         core_reset;
    logic         core_prompt;
    logic         core_ready;
    logic [W-1:0] core_result;

    modport slave (
        input  in_valid, in_a, in_b, in_mode, out_ready, core_ready, core_result,
        output in_ready, out_valid, out_result, out_mode, out_err,
        output core_a, core_b, core_reset, core_prompt
    );

    modport master (
        output in_valid, in_a, in_b, in_mode, out_ready, core_ready, core_result,
        input  in_ready, out_valid, out_result, out_mode, out_err,
        input  core_a, core_b, core_reset, core_prompt
    );

endinterface

// File: rtl/gcd_lcm_job_fifo.sv
// Synchronous job FIFO with full/empty flags.
//   clk, reset : clock, synchronous active-low reset (empties the FIFO)
//   push_i     : write data_i (caller guarantees !full_o)
//   pop_i      : advance head (caller guarantees !empty_o)
//   data_o     : current head entry
//   full_o, empty_o : occupancy flags
// Depth must be a power of two so the pointers wrap naturally.
module gcd_lcm_job_fifo #(
    parameter int unsigned Width = 17,
    parameter int unsigned Depth = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [PtrW:0]    count_q;

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == (PtrW + 1)'(Depth));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/gcd_lcm_dispatcher.sv
// Job dispatcher for the combined GCD/LCM core: queues jobs in a FIFO, runs them on
// the core one at a time and presents each result downstream.
//   clk, reset : clock, synchronous active-low reset (discards active and queued jobs)
//   bus        : job stream, result stream and core interface (slave modport)
//   busy       : FSM not idle, or jobs queued
// Optional: define GCD_LCM_DISPATCH_TIMEOUT_EN to abort a job after TIMEOUT RUN cycles
// without core_ready (out_err=1, out_result=0).
module gcd_lcm_dispatcher
    import gcd_lcm_pkg::*;
#(
    parameter int unsigned W          = W_DEFAULT,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned RST_CYC    = 2,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    gcd_lcm_dispatcher_if.slave  bus,
    output logic                 busy
);

    localparam int unsigned JobW = 2 * W + 1;
    localparam int unsigned CntW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

    logic            push, pop, fifo_full, fifo_empty;
    logic [JobW-1:0] head;
    logic [W-1:0]    head_a, head_b;
    logic            head_mode;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic            run_first_q;
    logic [W-1:0]    core_a_q, core_b_q, out_result_q;
    logic            core_prompt_q, core_reset_q, out_valid_q, out_mode_q;

    assign push = bus.in_valid && !fifo_full && reset;
    assign pop  = (state_q == StIdle) && !fifo_empty;

    gcd_lcm_job_fifo #(
        .Width(JobW),
        .Depth(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push_i (push),
        .data_i ({bus.in_a, bus.in_b, bus.in_mode}),
        .pop_i  (pop),
        .data_o (head),
        .full_o (fifo_full),
        .empty_o(fifo_empty)
    );

    assign head_a    = head[2*W:W+1];
    assign head_b    = head[W:1];
    assign head_mode = head[0];

`ifdef GCD_LCM_DISPATCH_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
    logic [TmoW-1:0] tmo_q;
    logic            out_err_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            run_first_q   <= 1'b0;
            core_a_q      <= '0;
            core_b_q      <= '0;
            core_prompt_q <= 1'b0;
            core_reset_q  <= 1'b1;
            out_valid_q   <= 1'b0;
            out_result_q  <= '0;
            out_mode_q    <= 1'b0;
`ifdef GCD_LCM_DISPATCH_TIMEOUT_EN
            tmo_q         <= '0;
            out_err_q     <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!fifo_empty) begin
                        core_a_q      <= head_a;
                        core_b_q      <= head_b;
                        core_prompt_q <= head_mode;
                        core_reset_q  <= 1'b1;
                        if (head_a == '0 || head_b == '0) begin
                            // One operand is zero, so a|b is the GCD; the LCM is zero.
                            out_result_q <= (head_mode == MODE_LCM) ? '0 : (head_a | head_b);
                            out_mode_q   <= head_mode;
                            out_valid_q  <= 1'b1;
                            state_q      <= StHold;
                        end else begin
                            cnt_q   <= CntW'(RST_CYC - 1);
                            state_q <= StLoad;
                        end
                    end else begin
                        // Release the core only while nothing is queued or arriving.
                        core_reset_q <= push;
                    end
                end
                StLoad: begin
                    if (cnt_q == '0) begin
                        core_reset_q <= 1'b0;
                        run_first_q  <= 1'b1;
`ifdef GCD_LCM_DISPATCH_TIMEOUT_EN
                        tmo_q        <= '0;
`endif
                        state_q      <= StRun;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StRun: begin
                    run_first_q <= 1'b0;
                    // The first RUN cycle may still see ready left over from the last job.
                    if (!run_first_q && bus.core_ready) begin
                        out_result_q <= bus.core_result;
                        out_mode_q   <= core_prompt_q;
                        out_valid_q  <= 1'b1;
                        state_q      <= StHold;
                    end
`ifdef GCD_LCM_DISPATCH_TIMEOUT_EN
                    else if (tmo_q == TmoW'(TIMEOUT - 1)) begin
                        out_result_q <= '0;
                        out_mode_q   <= core_prompt_q;
                        out_err_q    <= 1'b1;
                        out_valid_q  <= 1'b1;
                        core_reset_q <= 1'b1;
                        state_q      <= StHold;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
`endif
                end
                StHold: begin
                    if (bus.out_ready) begin
                        out_valid_q  <= 1'b0;
                        core_reset_q <= !fifo_empty || push;
`ifdef GCD_LCM_DISPATCH_TIMEOUT_EN
                        out_err_q    <= 1'b0;
`endif
                        state_q      <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready    = reset && !fifo_full;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_result  = out_result_q;
    assign bus.out_mode    = out_mode_q;
    assign bus.core_a      = core_a_q;
    assign bus.core_b      = core_b_q;
    assign bus.core_reset  = core_reset_q;
    assign bus.core_prompt = core_prompt_q;
`ifdef GCD_LCM_DISPATCH_TIMEOUT_EN
    assign bus.out_err     = out_err_q;
`else
    assign bus.out_err     = 1'b0;
`endif
    assign busy = (state_q != StIdle) || !fifo_empty;

endmodule

// File: tb/tb_gcd_lcm_dispatcher.sv
// Directed self-checking bench for gcd_lcm_dispatcher with a small behavioural core.
module tb_gcd_lcm_dispatcher;
    import gcd_lcm_pkg::*;

    logic clk;
    logic reset;
    logic busy;
    int   tests;
    int   fails;

    logic       core_auto;
    logic       man_ready;
    logic [7:0] man_result;
    logic       auto_ready = 1'b0;
    logic [7:0] auto_result = 8'd0;
    int         core_cnt = 0;

    gcd_lcm_dispatcher_if #(.W(8)) bus ();

    gcd_lcm_dispatcher #(
        .W(8),
        .FIFO_DEPTH(4),
        .RST_CYC(2),
        .TIMEOUT(20)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] core_fn(input logic [7:0] a, input logic [7:0] b,
                                           input logic m);
        logic [7:0] x = a;
        logic [7:0] y = b;
        logic [7:0] t;
        while (y != 8'd0) begin
            t = x % y;
            x = y;
            y = t;
        end
        if (m == MODE_LCM) return (x == 8'd0) ? 8'd0 : (a / x) * b;
        return x;
    endfunction

    // Behavioural core: answers 4 cycles after reset release, holds ready until reset.
    always @(posedge clk) begin
        if (bus.core_reset) begin
            core_cnt   <= 0;
            auto_ready <= 1'b0;
        end else if (core_cnt < 3) begin
            core_cnt <= core_cnt + 1;
        end else begin
            auto_ready  <= 1'b1;
            auto_result <= core_fn(bus.core_a, bus.core_b, bus.core_prompt);
        end
    end

    assign bus.core_ready  = core_auto ? auto_ready : man_ready;
    assign bus.core_result = core_auto ? auto_result : man_result;

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic push_job(input logic [7:0] a, input logic [7:0] b, input logic m);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_mode  = m;
        while (bus.in_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            tests++;
            fails++;
            $display("FAIL push_wait in_ready got %0b want 1", bus.in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (bus.out_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (bus.out_valid !== 1'b1) begin
            fails++;
            $display("FAIL %s out_valid_wait got %0b want 1", tag, bus.out_valid);
        end
    endtask

    task automatic handshake();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic wait_run();
        int n = 0;
        while (bus.core_reset !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (bus.core_reset !== 1'b0) begin
            fails++;
            $display("FAIL run_wait core_reset got %0b want 0", bus.core_reset);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        @(negedge clk);
        tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL rst_in_ready got %0b want 0", bus.in_ready); end
        @(negedge clk);
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid got %0b want 0", bus.out_valid); end
        tests++; if (bus.out_result !== 8'd0) begin fails++; $display("FAIL rst_out_result got %0d want 0", bus.out_result); end
        tests++; if (bus.out_mode !== 1'b0) begin fails++; $display("FAIL rst_out_mode got %0b want 0", bus.out_mode); end
        tests++; if (bus.out_err !== 1'b0) begin fails++; $display("FAIL rst_out_err got %0b want 0", bus.out_err); end
        tests++; if (bus.core_a !== 8'd0 || bus.core_b !== 8'd0) begin fails++; $display("FAIL rst_core_ab got %0d,%0d want 0,0", bus.core_a, bus.core_b); end
        tests++; if (bus.core_prompt !== 1'b0) begin fails++; $display("FAIL rst_core_prompt got %0b want 0", bus.core_prompt); end
        tests++; if (bus.core_reset !== 1'b1) begin fails++; $display("FAIL rst_core_reset got %0b want 1", bus.core_reset); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy got %0b want 0", busy); end
        reset = 1'b1;
        #1;
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL rst_release_in_ready got %0b want 1", bus.in_ready); end
        @(negedge clk);
    endtask

    task automatic test_single(input logic m, input logic [7:0] exp_r, input string tag);
        push_job(8'd20, 8'd12, m);
        @(negedge clk);
        tests++; if (bus.core_reset !== 1'b1) begin fails++; $display("FAIL %s load1_core_reset got %0b want 1", tag, bus.core_reset); end
        tests++; if (bus.core_a !== 8'd20 || bus.core_b !== 8'd12) begin fails++; $display("FAIL %s core_ab got %0d,%0d want 20,12", tag, bus.core_a, bus.core_b); end
        tests++; if (bus.core_prompt !== m) begin fails++; $display("FAIL %s core_prompt got %0b want %0b", tag, bus.core_prompt, m); end
        @(negedge clk);
        tests++; if (bus.core_reset !== 1'b1) begin fails++; $display("FAIL %s load2_core_reset got %0b want 1", tag, bus.core_reset); end
        @(negedge clk);
        tests++; if (bus.core_reset !== 1'b0) begin fails++; $display("FAIL %s run_core_reset got %0b want 0", tag, bus.core_reset); end
        wait_valid(tag);
        tests++; if (bus.out_result !== exp_r) begin fails++; $display("FAIL %s out_result got %0d want %0d", tag, bus.out_result, exp_r); end
        tests++; if (bus.out_mode !== m) begin fails++; $display("FAIL %s out_mode got %0b want %0b", tag, bus.out_mode, m); end
        tests++; if (bus.out_err !== 1'b0) begin fails++; $display("FAIL %s out_err got %0b want 0", tag, bus.out_err); end
        repeat (3) @(negedge clk);
        tests++; if (bus.out_valid !== 1'b1 || bus.out_result !== exp_r) begin fails++; $display("FAIL %s hold got v=%0b r=%0d want v=1 r=%0d", tag, bus.out_valid, bus.out_result, exp_r); end
        handshake();
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL %s after_hs out_valid got %0b want 0", tag, bus.out_valid); end
    endtask

    logic [7:0] bb_a [5];
    logic [7:0] bb_b [5];
    logic       bb_m [5];
    logic [7:0] bb_r [5];

    task automatic test_back_to_back();
        bb_a = '{8'd9, 8'd4, 8'd7, 8'd3, 8'd8};
        bb_b = '{8'd6, 8'd6, 8'd5, 8'd5, 8'd12};
        bb_m = '{MODE_GCD, MODE_LCM, MODE_GCD, MODE_LCM, MODE_GCD};
        bb_r = '{8'd3, 8'd12, 8'd1, 8'd15, 8'd4};
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_job(bb_a[i], bb_b[i], bb_m[i]);
        tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL b2b_full in_ready got %0b want 0", bus.in_ready); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL b2b_busy got %0b want 1", busy); end
        for (int i = 0; i < 5; i++) begin
            wait_valid("b2b");
            tests++; if (bus.out_result !== bb_r[i] || bus.out_mode !== bb_m[i]) begin fails++; $display("FAIL b2b_job%0d got r=%0d m=%0b want r=%0d m=%0b", i, bus.out_result, bus.out_mode, bb_r[i], bb_m[i]); end
            handshake();
        end
        repeat (2) @(negedge clk);
        tests++; if (busy !== 1'b0 || bus.in_ready !== 1'b1) begin fails++; $display("FAIL b2b_drain got busy=%0b in_ready=%0b want 0,1", busy, bus.in_ready); end
    endtask

    task automatic test_bypass();
        bb_a = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        bb_b = '{8'd15, 8'd15, 8'd0, 8'd0, 8'd0};
        bb_m = '{MODE_GCD, MODE_LCM, MODE_GCD, MODE_GCD, MODE_GCD};
        bb_r = '{8'd15, 8'd0, 8'd0, 8'd0, 8'd0};
        for (int i = 0; i < 3; i++) begin
            push_job(bb_a[i], bb_b[i], bb_m[i]);
            tests++; if (bus.out_valid !== 1'b0 || bus.core_reset !== 1'b1) begin fails++; $display("FAIL byp%0d cyc2 got v=%0b cr=%0b want 0,1", i, bus.out_valid, bus.core_reset); end
            @(negedge clk);
            tests++; if (bus.out_valid !== 1'b1 || bus.out_result !== bb_r[i] || bus.out_mode !== bb_m[i]) begin fails++; $display("FAIL byp%0d cyc3 got v=%0b r=%0d m=%0b want 1,%0d,%0b", i, bus.out_valid, bus.out_result, bus.out_mode, bb_r[i], bb_m[i]); end
            @(negedge clk);
            tests++; if (bus.core_reset !== 1'b1) begin fails++; $display("FAIL byp%0d hold core_reset got %0b want 1", i, bus.core_reset); end
            handshake();
        end
    endtask

    task automatic test_stale_ready();
        core_auto  = 1'b0;
        man_ready  = 1'b0;
        man_result = 8'hAA;
        push_job(8'd18, 8'd12, MODE_GCD);
        wait_run();
        man_ready = 1'b1;
        @(negedge clk);
        man_ready = 1'b0;
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL stale_ready out_valid got %0b want 0", bus.out_valid); end
        repeat (2) @(negedge clk);
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL stale_wait out_valid got %0b want 0", bus.out_valid); end
        man_result = 8'd6;
        man_ready  = 1'b1;
        @(negedge clk);
        man_ready = 1'b0;
        tests++; if (bus.out_valid !== 1'b1 || bus.out_result !== 8'd6) begin fails++; $display("FAIL stale_capture got v=%0b r=%0d want 1,6", bus.out_valid, bus.out_result); end
        handshake();
        core_auto = 1'b1;
    endtask

    task automatic test_reset_mid_run();
        logic seen = 1'b0;
        core_auto = 1'b0;
        man_ready = 1'b0;
        push_job(8'd20, 8'd12, MODE_LCM);
        wait_run();
        push_job(8'd9, 8'd6, MODE_GCD);
        reset = 1'b0;
        #1;
        tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL mid_rst in_ready got %0b want 0", bus.in_ready); end
        @(negedge clk);
        tests++; if (bus.out_valid !== 1'b0 || bus.out_result !== 8'd0 || bus.out_mode !== 1'b0) begin fails++; $display("FAIL mid_rst out got v=%0b r=%0d m=%0b want 0,0,0", bus.out_valid, bus.out_result, bus.out_mode); end
        tests++; if (bus.core_reset !== 1'b1 || bus.core_a !== 8'd0 || bus.core_prompt !== 1'b0) begin fails++; $display("FAIL mid_rst core got cr=%0b a=%0d p=%0b want 1,0,0", bus.core_reset, bus.core_a, bus.core_prompt); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_rst busy got %0b want 0", busy); end
        reset     = 1'b1;
        core_auto = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        tests++; if (seen !== 1'b0) begin fails++; $display("FAIL mid_rst_discard got activity=%0b want 0", seen); end
    endtask

`ifdef GCD_LCM_DISPATCH_TIMEOUT_EN
    task automatic test_timeout();
        core_auto = 1'b0;
        man_ready = 1'b0;
        push_job(8'd20, 8'd12, MODE_LCM);
        wait_valid("timeout");
        tests++; if (bus.out_err !== 1'b1 || bus.out_result !== 8'd0) begin fails++; $display("FAIL timeout got err=%0b r=%0d want 1,0", bus.out_err, bus.out_result); end
        tests++; if (bus.core_reset !== 1'b1 || bus.out_mode !== 1'b1) begin fails++; $display("FAIL timeout got cr=%0b m=%0b want 1,1", bus.core_reset, bus.out_mode); end
        handshake();
        tests++; if (bus.out_err !== 1'b0 || bus.out_valid !== 1'b0) begin fails++; $display("FAIL timeout_clear got err=%0b v=%0b want 0,0", bus.out_err, bus.out_valid); end
        core_auto = 1'b1;
    endtask
`endif

    initial begin
        tests         = 0;
        fails         = 0;
        reset         = 1'b1;
        core_auto     = 1'b1;
        man_ready     = 1'b0;
        man_result    = 8'd0;
        bus.in_valid  = 1'b0;
        bus.in_a      = 8'd0;
        bus.in_b      = 8'd0;
        bus.in_mode   = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_single(MODE_GCD, 8'd4, "gcd");
        test_single(MODE_LCM, 8'd60, "lcm");
        test_back_to_back();
        test_bypass();
        test_stale_ready();
        test_reset_mid_run();
`ifdef GCD_LCM_DISPATCH_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gcd_lcm_dispatcher.md
Name: gcd_lcm_dispatcher

Overview:
Upstream job stage for the combined GCD/LCM core. It accepts operand pairs and a mode over a valid/ready stream and buffers them in a small FIFO. It sequences the core one job at a time: loads operands, pulses the core's reset, sets prompt, waits for the core's ready, then presents the captured result downstream with valid/ready.

Parameters:
W, 8, operand/result width; must match the core.
FIFO_DEPTH, 4, input job FIFO entries; power of two, at least 2.
RST_CYC, 2, cycles the core reset is held high per job; at least 1.
TIMEOUT, 255, max RUN cycles before abort; used only with the optional feature.

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-low reset
in_valid  in  1  job offered
in_ready  out  1  job accepted when in_valid && in_ready
in_a  in  W  operand A
in_b  in  W  operand B
in_mode  in  1  0 = GCD, 1 = LCM
out_valid  out  1  result available
out_ready  in  1  downstream accepts the result
out_result  out  W  GCD or LCM value
out_mode  out  1  mode of the job that produced out_result
out_err  out  1  job aborted by timeout (optional feature only; tied 0 otherwise)
core_a  out  W  to core A
core_b  out  W  to core B
core_reset  out  1  to core reset (active-high)
core_prompt  out  1  to core prompt (mode)
core_ready  in  1  from core ready
core_result  in  W  from core result
busy  out  1  FSM not in IDLE, or FIFO not empty

Behaviour:
- Reset (reset==0 at a clk edge):
  - FIFO emptied; FSM goes to IDLE.
  - in_ready=0 during reset, then 1 on the first cycle after release.
  - out_valid=0, out_result=0, out_mode=0, out_err=0.
  - core_a=0, core_b=0, core_prompt=0, core_reset=1 (core held in reset), busy=0.
  - Reset mid-job discards the job and any queued jobs; no output is produced for them.
- FIFO:
  - in_ready = !full. A push while full is impossible.
  - Simultaneous push and pop in the same cycle are both performed.
  - Pop happens only from IDLE when the FIFO is not empty.
- FSM states: IDLE, LOAD, RUN, HOLD.
  - IDLE: if the FIFO is not empty, pop the head and register a/b/mode onto core_a/core_b/core_prompt.
    - If a==0 or b==0 (bypass): the result is computed locally and the FSM goes straight to HOLD next cycle. GCD gives the nonzero operand (0 if both are 0); LCM gives 0.
    - Otherwise go to LOAD with core_reset=1.
  - core_reset is 0 in IDLE only when the FIFO is empty and no job is active. It stays 1 across back-to-back jobs.
  - LOAD: core_reset=1 for exactly RST_CYC cycles, counted from the IDLE→LOAD edge. Then core_reset=0 and go to RUN.
  - RUN: core_reset=0 and core_a/core_b/core_prompt stay stable.
    - core_ready is ignored in the first RUN cycle (stale-ready guard).
    - From the second cycle on, core_ready==1 captures core_result into out_result, sets out_valid=1, and goes to HOLD.
  - HOLD: out_valid=1 with out_result/out_mode held stable. On out_valid && out_ready, clear out_valid and go to IDLE.
    - The next job can pop in the IDLE cycle that follows, giving a 1-cycle bubble.
- Latency:
  - Core job: push to out_valid = 1 (FIFO) + 1 (IDLE) + RST_CYC + core cycles + 1.
  - Bypass job: push to out_valid = 3 cycles.
- Arithmetic: no width growth. LCM overflow is the core's concern; core_result is passed through unmodified.
- Downstream stall: HOLD persists indefinitely and the FIFO keeps accepting until full.

Optional Feature:
GCD_LCM_DISPATCH_TIMEOUT_EN
- Defined:
  - A RUN-cycle counter is active. If TIMEOUT cycles elapse without core_ready, the FSM goes to HOLD with out_result=0, out_err=1, and core_reset=1.
  - out_err is cleared on handshake.
- Undefined: no counter; RUN waits forever; out_err is constant 0.

Decomposition:
- Package gcd_lcm_pkg holds:
  - state enum (IDLE/LOAD/RUN/HOLD)
  - MODE_GCD=1'b0, MODE_LCM=1'b1
  - W default
- Sub-module gcd_lcm_job_fifo: parameterised synchronous FIFO (W+W+1 bits, FIFO_DEPTH entries) with full/empty flags and the same reset.

Test Plan:
- Single GCD: push (20,12,0) → core_reset high for 2 cycles then low, core_prompt=0; after core_ready, out_result=4 and out_mode=0, held until out_ready.
- Single LCM: push (20,12,1) → core_prompt=1, out_result=60 and out_mode=1.
- Back-to-back with stalled out_ready: push 5 jobs (GCD 9,6 / LCM 4,6 / GCD 7,5 / LCM 3,5 / GCD 8,12) with out_ready=0.
  - in_ready drops after the FIFO fills.
  - Results appear in order (3, 12, 1, 15, 4) as out_ready is released.
- Bypass: (0,15,0) → 15; (0,15,1) → 0; (0,0,0) → 0.
  - Each has out_valid 3 cycles after push and core_reset never deasserts.
- Stale ready: hold core_ready=1 in the first RUN cycle then drop it → no capture; a later core_ready pulse captures correctly.
- Reset mid-RUN: reset low for 1 cycle → all outputs at reset values, FIFO empty, no output for the aborted job. With the feature defined, a core that never asserts ready gives out_err=1 and out_result=0 after TIMEOUT cycles.
